regbank_arbiter: RTL and testbench

- Arbitrates two independent requesters onto the single port set of the 8x8 register bank: one write port and two combinational read ports.
- Each accepted request is one operation: an optional write plus two reads. Its read data comes back as a registered response one cycle later.
- Sits between the bank and its clients, for example a decode stage and a debug/load engine. Round-robin fairness, with an optional bounded lock for back-to-back ownership.

---
 rtl/regbank_pkg.sv | 27 ++
 rtl/regbank_arbiter_rr_arb2.sv | 13 +
 rtl/regbank_arbiter.sv | 95 +++++++++
 tb/tb_regbank_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// regbank_pkg: shared widths, arbiter state and request record for regbank_arbiter
package regbank_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  typedef enum logic {ARB, LOCKED} arb_state_e;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
  } req_t;
  function automatic req_t unpack_req(
    input logic [1:0]          we,
    input logic [2*ADDR_W-1:0] waddr,
    input logic [2*DATA_W-1:0] wdata,
    input logic [2*ADDR_W-1:0] raddr1,
    input logic [2*ADDR_W-1:0] raddr2,
    input int                  i
  );
    unpack_req.we     = we[i];
    unpack_req.waddr  = waddr[i*ADDR_W +: ADDR_W];
    unpack_req.wdata  = wdata[i*DATA_W +: DATA_W];
    unpack_req.raddr1 = raddr1[i*ADDR_W +: ADDR_W];
    unpack_req.raddr2 = raddr2[i*ADDR_W +: ADDR_W];
  endfunction
endpackage

// File: rtl/regbank_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant, pointer moves to the loser after each grant
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  output logic [1:0] gnt
);
  logic rr;
  always_comb gnt = valid[rr] ? (rr ? 2'b10 : 2'b01) : (valid[!rr] ? (rr ? 2'b01 : 2'b10) : 2'b00);
  always_ff @(posedge clk or negedge rst)
    if (!rst) rr <= 1'b0;
    else if (|gnt) rr <= ~gnt[1];
endmodule

// File: rtl/regbank_arbiter.sv
// regbank_arbiter: two-client round-robin/lock arbiter for the 8x8 register bank
// REGBANK_ARB_FWD_EN forwards same-op write data onto matching read responses
module regbank_arbiter #(
  parameter int DATA_W   = regbank_pkg::DATA_W,
  parameter int ADDR_W   = regbank_pkg::ADDR_W,
  parameter int MAX_LOCK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_lock,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_waddr,
  input  logic [2*DATA_W-1:0] req_wdata,
  input  logic [2*ADDR_W-1:0] req_raddr1,
  input  logic [2*ADDR_W-1:0] req_raddr2,
  output logic                bank_we,
  output logic [ADDR_W-1:0]   bank_waddr,
  output logic [DATA_W-1:0]   bank_wdata,
  output logic [ADDR_W-1:0]   bank_raddr1,
  output logic [ADDR_W-1:0]   bank_raddr2,
  input  logic [DATA_W-1:0]   bank_rdata1,
  input  logic [DATA_W-1:0]   bank_rdata2,
  output logic [1:0]          resp_valid,
  output logic [DATA_W-1:0]   resp_rdata1,
  output logic [DATA_W-1:0]   resp_rdata2
);
  import regbank_pkg::*;
  arb_state_e state, state_d;
  logic owner, owner_d;
  logic [3:0] lock_cnt, lock_cnt_d;
  logic [1:0] eligible, gnt;
  logic g, granted;
  req_t r;
  logic [DATA_W-1:0] rd1, rd2;
  // while locked only the owner is presented to the round-robin core
  assign eligible = state == LOCKED ? req_valid & (owner ? 2'b10 : 2'b01) : req_valid;
  rr_arb2 u_arb (.clk(clk), .rst(rst), .valid(eligible), .gnt(gnt));
  assign req_ready = rst ? gnt : 2'b00;
  assign granted = |req_ready;
  assign g = req_ready[1];
  assign r = unpack_req(req_we, req_waddr, req_wdata, req_raddr1, req_raddr2, int'(g));
  assign bank_we = granted & r.we;
  assign bank_waddr = granted ? r.waddr : '0;
  assign bank_wdata = granted ? r.wdata : '0;
  assign bank_raddr1 = granted ? r.raddr1 : '0;
  assign bank_raddr2 = granted ? r.raddr2 : '0;
`ifdef REGBANK_ARB_FWD_EN
  assign rd1 = r.we && r.waddr != '0 && r.raddr1 == r.waddr ? r.wdata : bank_rdata1;
  assign rd2 = r.we && r.waddr != '0 && r.raddr2 == r.waddr ? r.wdata : bank_rdata2;
`else
  assign rd1 = bank_rdata1;
  assign rd2 = bank_rdata2;
`endif
  always_comb begin
    state_d = state;
    owner_d = owner;
    lock_cnt_d = lock_cnt;
    if (state == ARB) begin
      if (granted && req_lock[g] && MAX_LOCK > 1) begin
        state_d = LOCKED;
        owner_d = g;
        lock_cnt_d = 4'd1;
      end
    end else if (req_valid[owner] && req_lock[owner] && int'(lock_cnt) + 1 < MAX_LOCK) begin
      lock_cnt_d = lock_cnt + 4'd1;
    end else begin
      state_d = ARB;
      lock_cnt_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= ARB;
      owner <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      lock_cnt <= lock_cnt_d;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      resp_valid <= '0;
      resp_rdata1 <= '0;
      resp_rdata2 <= '0;
    end else begin
      resp_valid <= req_ready;
      if (granted) begin
        resp_rdata1 <= rd1;
        resp_rdata2 <= rd2;
      end
    end
endmodule

// File: tb/tb_regbank_arbiter.sv
// tb_regbank_arbiter: scoreboard bench with a bank model for regbank_arbiter
module tb_regbank_arbiter;
  localparam int DW = 8;
  localparam int AW = 3;
  logic test_clk = 1'b0;
  always #5 test_clk = ~test_clk;
  logic rst;
  logic [1:0] req_valid, req_ready, req_lock, req_we, resp_valid;
  logic [2*AW-1:0] req_waddr, req_raddr1, req_raddr2;
  logic [2*DW-1:0] req_wdata;
  logic bank_we;
  logic [AW-1:0] bank_waddr, bank_raddr1, bank_raddr2;
  logic [DW-1:0] bank_wdata, bank_rdata1, bank_rdata2, resp_rdata1, resp_rdata2;
  logic [DW-1:0] bank_mem [8] = '{default: '0};
  logic [DW-1:0] ref_mem [8] = '{default: '0};
  typedef struct {
    logic [1:0]    v;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } resp_t;
  resp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  regbank_arbiter dut (
    .clk(test_clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_lock(req_lock), .req_we(req_we), .req_waddr(req_waddr), .req_wdata(req_wdata),
    .req_raddr1(req_raddr1), .req_raddr2(req_raddr2), .bank_we(bank_we),
    .bank_waddr(bank_waddr), .bank_wdata(bank_wdata), .bank_raddr1(bank_raddr1),
    .bank_raddr2(bank_raddr2), .bank_rdata1(bank_rdata1), .bank_rdata2(bank_rdata2),
    .resp_valid(resp_valid), .resp_rdata1(resp_rdata1), .resp_rdata2(resp_rdata2)
  );

  assign bank_rdata1 = bank_raddr1 == '0 ? '0 : bank_mem[bank_raddr1];
  assign bank_rdata2 = bank_raddr2 == '0 ? '0 : bank_mem[bank_raddr2];
  always @(posedge test_clk) if (bank_we && bank_waddr != '0) bank_mem[bank_waddr] <= bank_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic lk, input logic we,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
    req_valid[i] = v;
    req_lock[i] = lk;
    req_we[i] = we;
    req_waddr[i*AW +: AW] = wa;
    req_wdata[i*DW +: DW] = wd;
    req_raddr1[i*AW +: AW] = ra1;
    req_raddr2[i*AW +: AW] = ra2;
  endtask

  task automatic idle(input int i);
    drive(i, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0);
  endtask

  function automatic logic [DW-1:0] rd_exp(input int g, input logic [AW-1:0] ra);
    logic [AW-1:0] wa;
    wa = req_waddr[g*AW +: AW];
    if (ra == '0) return '0;
`ifdef REGBANK_ARB_FWD_EN
    if (req_we[g] && ra == wa) return req_wdata[g*DW +: DW];
`endif
    return ref_mem[ra];
  endfunction

  task automatic cycle(input string tag, input logic [1:0] eg);
    resp_t e;
    int g;
    logic [AW-1:0] wa;
    @(negedge test_clk);
    chk({tag, " ready"}, 32'(req_ready), 32'(eg));
    if (eg != 2'b00) begin
      g = eg[1] ? 1 : 0;
      wa = req_waddr[g*AW +: AW];
      e.v = eg;
      e.d1 = rd_exp(g, req_raddr1[g*AW +: AW]);
      e.d2 = rd_exp(g, req_raddr2[g*AW +: AW]);
      chk({tag, " bank_we"}, 32'(bank_we), 32'(req_we[g]));
      if (req_we[g] && wa != '0) ref_mem[wa] = req_wdata[g*DW +: DW];
      sb.push_back(e);
    end else chk({tag, " bank_we"}, 32'(bank_we), 32'd0);
    @(posedge test_clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, " resp_valid"}, 32'(resp_valid), 32'(e.v));
      chk({tag, " rdata1"}, 32'(resp_rdata1), 32'(e.d1));
      chk({tag, " rdata2"}, 32'(resp_rdata2), 32'(e.d2));
    end else chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0; req_lock = '0; req_we = '0;
    req_waddr = '0; req_wdata = '0; req_raddr1 = '0; req_raddr2 = '0;
    drive(0, 1'b1, 1'b1, 1'b1, 3'd1, 8'h11, 3'd1, 3'd2);
    cycle("in_rst", 2'b00);
    chk("rst rdata1", 32'(resp_rdata1), 32'd0);
    chk("rst rdata2", 32'(resp_rdata2), 32'd0);
    chk("rst raddr1", 32'(bank_raddr1), 32'd0);
    chk("rst wdata", 32'(bank_wdata), 32'd0);
    idle(0);
    rst = 1'b1;
    cycle("idle", 2'b00);
    drive(0, 1'b1, 1'b0, 1'b1, 3'd1, 8'hAA, 3'd1, 3'd0);
    cycle("wr_x1", 2'b01);
    drive(0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd1);
    cycle("rd_x1", 2'b01);
    idle(0);
    drive(1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd0);
    cycle("rd1_x1", 2'b10);
    drive(0, 1'b1, 1'b0, 1'b1, 3'd2, 8'hBB, 3'd0, 3'd0);
    drive(1, 1'b1, 1'b0, 1'b1, 3'd3, 8'hCC, 3'd0, 3'd0);
    cycle("cont0", 2'b01);
    cycle("cont1", 2'b10);
    cycle("cont2", 2'b01);
    cycle("cont3", 2'b10);
    idle(1);
    drive(0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd3);
    cycle("rd_x2x3", 2'b01);
    drive(0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd0);
    drive(1, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 3'd2, 3'd3);
    for (int k = 0; k < 4; k++) cycle("lock1", 2'b10);
    cycle("lock_rel", 2'b01);
    idle(0);
    idle(1);
    drive(0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 3'd1, 3'd1);
    cycle("lock0_a", 2'b01);
    cycle("lock0_b", 2'b01);
    drive(0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd1);
    drive(1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd2);
    cycle("unlock", 2'b01);
    cycle("early_rel", 2'b10);
    idle(1);
    drive(0, 1'b1, 1'b1, 1'b1, 3'd4, 8'h5A, 3'd4, 3'd0);
    cycle("lock0_c", 2'b01);
    rst = 1'b0;
    #1;
    chk("midrst resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst ready", 32'(req_ready), 32'd0);
    chk("midrst rdata1", 32'(resp_rdata1), 32'd0);
    drive(0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd1);
    drive(1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd4);
    cycle("in_rst2", 2'b00);
    rst = 1'b1;
    cycle("post_rst0", 2'b01);
    cycle("post_rst1", 2'b10);
    idle(0);
    idle(1);
    cycle("tail", 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
